router_fsm: RTL and testbench

Packet-sequencing controller for the 1x3 router. It watches the input packet stream, decodes the destination from the header, and waits for the target output FIFO to drain before a new packet starts. It drives the FIFO write enables and the `lfd_state` header marker, stalls the source on full, and sequences the parity byte. It also owns the three per-port soft-reset timeout counters that flush a `router_fifo` whose reader has stalled.

---
 rtl/router_fsm.sv | 190 +++++++++++++++++++
 tb/tb_router_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: header decode, FIFO write
// enables, source stall and per-port soft-reset timeout counters.
module router_fsm #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din_addr,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] fifo_full,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic [2:0] write_enb,
  output logic       write_enb_reg,
  output logic [2:0] vld_out,
  output logic [2:0] soft_rst,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t            state_r, state_next_s;
  logic [1:0]        addr_r;
  logic [CNT_W-1:0]  cnt_r [3];
  logic [2:0]        inc_s;
  logic              full_s, empty_s, din_empty_s, port_srst_s;

  // Per-port flag select; address 3 never addresses a FIFO.
  function automatic logic sel3(input logic [2:0] v, input logic [1:0] a);
    logic r;
    case (a)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign vld_out     = ~fifo_empty;
  assign inc_s       = vld_out & ~read_enb;
  assign full_s      = sel3(fifo_full, addr_r);
  assign empty_s     = sel3(fifo_empty, addr_r);
  assign din_empty_s = sel3(fifo_empty, din_addr);
  assign port_srst_s = sel3(soft_rst, addr_r);

  // Timeout pulse fires on the cycle the counter would pass TIMEOUT-1.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      soft_rst[i] = inc_s[i] && (cnt_r[i] == CNT_W'(TIMEOUT - 1));
    end
  end

  // Unread-cycle counters, one per output port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        cnt_r[i] <= '0;
      end else if (!inc_s[i] || soft_rst[i]) begin
        cnt_r[i] <= '0;
      end else begin
        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // State and latched destination address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= DECODE_ADDRESS;
      addr_r  <= 2'd0;
    end else begin
      state_r <= state_next_s;
      if (detect_add && pkt_valid && (din_addr != 2'd3)) begin
        addr_r <= din_addr;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // Next-state logic and Moore output decodes.
  always_comb begin
    state_next_s  = state_r;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    write_enb_reg = 1'b0;
    case (state_r)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        if (pkt_valid && (din_addr != 2'd3)) begin
          state_next_s = din_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end else begin
          state_next_s = DECODE_ADDRESS;
        end
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (empty_s) state_next_s = LOAD_FIRST_DATA;
        else         state_next_s = WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: begin
        lfd_state     = 1'b1;
        busy          = 1'b1;
        write_enb_reg = 1'b1;
        state_next_s  = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        if (full_s)          state_next_s = FIFO_FULL_STATE;
        else if (!pkt_valid) state_next_s = LOAD_PARITY;
        else                 state_next_s = LOAD_DATA;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
        if (!full_s) state_next_s = LOAD_AFTER_FULL;
        else         state_next_s = FIFO_FULL_STATE;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        busy          = 1'b1;
        write_enb_reg = 1'b1;
        if (parity_done)        state_next_s = DECODE_ADDRESS;
        else if (low_pkt_valid) state_next_s = LOAD_PARITY;
        else                    state_next_s = LOAD_DATA;
      end
      LOAD_PARITY: begin
        busy          = 1'b1;
        write_enb_reg = 1'b1;
        state_next_s  = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
        if (full_s) state_next_s = FIFO_FULL_STATE;
        else        state_next_s = DECODE_ADDRESS;
      end
      default: begin
        state_next_s = DECODE_ADDRESS;
      end
    endcase
    // A flush of the active port abandons the packet.
    if ((state_r != DECODE_ADDRESS) && port_srst_s) begin
      state_next_s = DECODE_ADDRESS;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Route the write qualifier to the latched port.
  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (addr_r)
        2'd0:    write_enb = 3'b001;
        2'd1:    write_enb = 3'b010;
        2'd2:    write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end else begin
      write_enb = 3'b000;
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm.
module tb_router_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] din_addr;
  logic [2:0] fifo_empty, fifo_full, read_enb;
  logic       parity_done, low_pkt_valid;
  logic [2:0] write_enb, vld_out, soft_rst;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy;
  int         checks_r = 0;
  int         errors_r = 0;
  int         lfd_cnt;

  router_fsm #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din_addr(din_addr),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb(write_enb), .write_enb_reg(write_enb_reg), .vld_out(vld_out),
    .soft_rst(soft_rst), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_r++;
    if (act !== exp) begin
      errors_r++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of the state decodes: {da,lfd,ld,laf,full,rst_int,busy}.
  function automatic logic [6:0] dec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
  endfunction

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; din_addr = 2'd0;
    fifo_empty = 3'b111; fifo_full = 3'b000; read_enb = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    tick(); tick();
    check_val("rst_dec", 32'(dec()), 32'h40);
    check_val("rst_we", 32'(write_enb), 32'h0);
    check_val("rst_srst", 32'(soft_rst), 32'h0);
    check_val("vld_comb", 32'(vld_out), 32'h0);
    rst = 1'b1;

    // Packet to port 1: header, 14 payload, parity.
    pkt_valid = 1'b1; din_addr = 2'd1;
    tick();
    lfd_cnt = 0;
    check_val("p1_lfd", 32'(dec()), 32'h21);
    check_val("p1_lfd_we", 32'(write_enb), 32'h2);
    lfd_cnt += int'(lfd_state);
    tick();
    for (int i = 1; i <= 14; i++) begin
      pkt_valid = (i < 14);
      check_val("p1_ld", 32'(dec()), 32'h10);
      check_val("p1_ld_we", 32'(write_enb), 32'h2);
      lfd_cnt += int'(lfd_state);
      tick();
    end
    check_val("p1_lp", 32'(dec()), 32'h01);
    check_val("p1_lp_we", 32'(write_enb), 32'h2);
    tick();
    check_val("p1_cpe", 32'(dec()), 32'h03);
    check_val("p1_cpe_we", 32'(write_enb), 32'h0);
    tick();
    check_val("p1_da", 32'(dec()), 32'h40);
    check_val("p1_lfd_once", 32'(lfd_cnt), 32'd1);

    // Port 2 busy: wait until empty.
    fifo_empty = 3'b011; pkt_valid = 1'b1; din_addr = 2'd2;
    tick();
    pkt_valid = 1'b0;
    check_val("wte", 32'(dec()), 32'h01);
    check_val("wte_we", 32'(write_enb), 32'h0);
    tick();
    check_val("wte_hold", 32'(dec()), 32'h01);
    fifo_empty = 3'b111;
    tick();
    check_val("wte_lfd", 32'(dec()), 32'h21);
    check_val("wte_lfd_we", 32'(write_enb), 32'h4);
    tick(); tick(); tick();
    check_val("p2_cpe", 32'(dec()), 32'h03);
    tick();

    // Port 0: full together with falling pkt_valid, then recovery.
    pkt_valid = 1'b1; din_addr = 2'd0;
    tick(); tick();
    check_val("p0_ld", 32'(dec()), 32'h10);
    fifo_full = 3'b001; pkt_valid = 1'b0;
    tick();
    check_val("ffs", 32'(dec()), 32'h05);
    check_val("ffs_we", 32'(write_enb), 32'h0);
    fifo_full = 3'b000; low_pkt_valid = 1'b1;
    tick();
    check_val("laf", 32'(dec()), 32'h09);
    check_val("laf_we", 32'(write_enb), 32'h1);
    tick();
    low_pkt_valid = 1'b0;
    check_val("laf_lp", 32'(dec()), 32'h01);
    tick();
    check_val("laf_cpe", 32'(dec()), 32'h03);
    tick();
    check_val("laf_da", 32'(dec()), 32'h40);

    // Address 3 is dropped.
    pkt_valid = 1'b1; din_addr = 2'd3;
    tick();
    pkt_valid = 1'b0;
    check_val("a3_dec", 32'(dec()), 32'h40);
    check_val("a3_we", 32'(write_enb), 32'h0);
    check_val("a3_addr", 32'(dut.addr_r), 32'h0);

    // Reset in LOAD_DATA.
    pkt_valid = 1'b1; din_addr = 2'd1;
    tick(); tick();
    check_val("mr_ld", 32'(dec()), 32'h10);
    rst = 1'b0;
    tick();
    rst = 1'b1; pkt_valid = 1'b0;
    check_val("mr_dec", 32'(dec()), 32'h40);
    check_val("mr_we", 32'(write_enb), 32'h0);

    // Timeout on port 1: pulse at cycle 30.
    fifo_empty = 3'b101;
    for (int k = 1; k <= 31; k++) begin
      #1;
      check_val($sformatf("to30_c%0d", k), 32'(soft_rst), (k == 30) ? 32'h2 : 32'h0);
      tick();
    end
    fifo_empty = 3'b111;
    tick();
    fifo_empty = 3'b101;
    for (int k = 1; k <= 51; k++) begin
      read_enb = (k == 20) ? 3'b010 : 3'b000;
      #1;
      check_val($sformatf("to50_c%0d", k), 32'(soft_rst[1]), (k == 50) ? 32'h1 : 32'h0);
      tick();
    end
    read_enb = 3'b000; fifo_empty = 3'b111;
    tick();

    // Flush of the waited-on port aborts WAIT_TILL_EMPTY.
    fifo_empty = 3'b011; pkt_valid = 1'b1; din_addr = 2'd2;
    tick();
    pkt_valid = 1'b0;
    for (int k = 2; k <= 30; k++) begin
      #1;
      check_val("sr_busy", 32'(busy), 32'h1);
      tick();
    end
    check_val("sr_da", 32'(dec()), 32'h40);
    fifo_empty = 3'b111;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end
endmodule
